// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings and default link timing,
// common to the DIF slow-control transmitter and receiver.
package uart_pkg;

  localparam int unsigned CLK_FREQ_DEFAULT = 40_000_000;
  localparam int unsigned BAUD_DEFAULT     = 38_400;

  typedef enum logic [2:0] {
    IDLE   = 3'b000,
    START  = 3'b001,
    DATA   = 3'b011,
    PARITY = 3'b111,
    STOP   = 3'b101
  } tx_state_e;

  // Clock cycles per bit, truncated
  function automatic int unsigned baud_div(input int unsigned clk_freq,
                                           input int unsigned baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_byte_tx_if.sv
// Byte-in valid/ready handshake between a producer and the UART transmitter.
interface uart_byte_tx_if #(
  parameter int unsigned DATA_BIT_NUM = 8
);
  logic [DATA_BIT_NUM-1:0] din;
  logic                    din_valid;
  logic                    din_ready;

  modport master (output din, output din_valid, input  din_ready);
  modport slave  (input  din, input  din_valid, output din_ready);
endinterface

// File: rtl/uart_baud_tick.sv
// Bit-period counter: one-cycle tick every BAUD_DIV clocks, held at zero
// while cleared.
module uart_baud_tick #(
  parameter int unsigned BAUD_DIV = 1041
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  output logic o_tick
);

  localparam int unsigned       CNT_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(BAUD_DIV - 1);

  logic [CNT_W-1:0] r_cnt;

  assign o_tick = !i_clear && (r_cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clear || o_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_byte_tx.sv
// UART byte transmitter: start bit, LSB-first data, optional even parity,
// stop bit. Accepts one byte per frame through a valid/ready handshake.
module uart_byte_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ     = CLK_FREQ_DEFAULT,
  parameter int unsigned BAUD         = BAUD_DEFAULT,
  parameter int unsigned DATA_BIT_NUM = 8,
  parameter int unsigned PARITY_EN    = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  uart_byte_tx_if.slave  in_if,
  output logic           tx,
  output logic           busy,
  output logic           done
);

  localparam int unsigned      BAUD_DIV = baud_div(CLK_FREQ, BAUD);
  localparam int unsigned      BIT_W    = (DATA_BIT_NUM > 1) ? $clog2(DATA_BIT_NUM) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BIT_NUM - 1);

  tx_state_e               r_state;
  logic [DATA_BIT_NUM-1:0] r_shift;
  logic [DATA_BIT_NUM-1:0] w_shift_nxt;
  logic [BIT_W-1:0]        r_bit_cnt;
  logic                    r_parity;
  logic                    r_tx;
  logic                    r_busy;
  logic                    r_done;
  logic                    w_idle;
  logic                    w_tick;

  assign w_idle          = (r_state == IDLE);
  assign in_if.din_ready = w_idle;
  assign w_shift_nxt     = r_shift >> 1;
  assign tx              = r_tx;
  assign busy            = r_busy;
  assign done            = r_done;

  uart_baud_tick #(
    .BAUD_DIV (BAUD_DIV)
  ) u_baud_tick (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clear (w_idle),
    .o_tick  (w_tick)
  );

  // tx is loaded one state ahead so each bit value lines up with the tick
  // that enters its state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_parity  <= 1'b0;
      r_tx      <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (in_if.din_valid) begin
            r_shift  <= in_if.din;
            r_parity <= ^in_if.din;
            r_tx     <= 1'b0;
            r_busy   <= 1'b1;
            r_state  <= START;
          end
        end
        START: begin
          if (w_tick) begin
            r_tx      <= r_shift[0];
            r_bit_cnt <= '0;
            r_state   <= DATA;
          end
        end
        DATA: begin
          if (w_tick) begin
            if (r_bit_cnt == LAST_BIT) begin
              if (PARITY_EN != 0) begin
                r_tx    <= r_parity;
                r_state <= PARITY;
              end else begin
                r_tx    <= 1'b1;
                r_state <= STOP;
              end
            end else begin
              r_shift   <= w_shift_nxt;
              r_tx      <= w_shift_nxt[0];
              r_bit_cnt <= r_bit_cnt + BIT_W'(1);
            end
          end
        end
        PARITY: begin
          if (w_tick) begin
            r_tx    <= 1'b1;
            r_state <= STOP;
          end
        end
        STOP: begin
          if (w_tick) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: begin
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
